// File: rtl/common_enums_pkg.sv
// Shared screen/time-setter types, preset limits and digit helpers.
package common_enums;

    typedef enum logic [1:0] {
        BOOT_SCREEN   = 2'd0,
        SETUP_SCREEN  = 2'd1,
        CHESS_SCREEN  = 2'd2,
        RESULT_SCREEN = 2'd3
    } screen_state_t;

    typedef logic [1:0] time_setter_state_t;

    localparam time_setter_state_t TS_IDLE  = 2'd0;
    localparam time_setter_state_t TS_EDIT  = 2'd1;
    localparam time_setter_state_t TS_OFFER = 2'd2;
    localparam time_setter_state_t TS_DONE  = 2'd3;

    localparam int unsigned CS_W  = 18;
    localparam int unsigned DIG_W = 4;
    localparam int unsigned SEG_W = 7;

    localparam logic [CS_W-1:0] MAX_PRESET_CS     = 18'd180000;
    localparam logic [CS_W-1:0] DEFAULT_PRESET_CS = 18'd6000;

    localparam logic [DIG_W-1:0] M1_MAX = 4'd3;
    localparam logic [DIG_W-1:0] M0_MAX = 4'd9;
    localparam logic [DIG_W-1:0] S1_MAX = 4'd5;
    localparam logic [DIG_W-1:0] S0_MAX = 4'd9;

    localparam logic [1:0] SEL_S0 = 2'd0;
    localparam logic [1:0] SEL_S1 = 2'd1;
    localparam logic [1:0] SEL_M0 = 2'd2;
    localparam logic [1:0] SEL_M1 = 2'd3;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    typedef struct packed {
        logic [DIG_W-1:0] m1;
        logic [DIG_W-1:0] m0;
        logic [DIG_W-1:0] s1;
        logic [DIG_W-1:0] s0;
    } digits_t;

    // 01:00
    localparam digits_t DEFAULT_DIGITS = 16'h0100;

    function automatic logic [DIG_W-1:0] digit_max(input logic [1:0] sel);
        case (sel)
            SEL_S0:  digit_max = S0_MAX;
            SEL_S1:  digit_max = S1_MAX;
            SEL_M0:  digit_max = M0_MAX;
            default: digit_max = M1_MAX;
        endcase
    endfunction

    // Full-width MM:SS to centiseconds; worst case 239900 still fits 18 bits.
    function automatic logic [CS_W-1:0] digits_to_cs(input digits_t d);
        logic [CS_W-1:0] mins;
        logic [CS_W-1:0] secs;
        logic [CS_W-1:0] total;
        mins  = CS_W'(d.m1) * 18'd10 + CS_W'(d.m0);
        secs  = CS_W'(d.s1) * 18'd10 + CS_W'(d.s0);
        total = mins * 18'd6000 + secs * 18'd100;
        digits_to_cs = (total > MAX_PRESET_CS) ? MAX_PRESET_CS : total;
    endfunction

endpackage

// File: rtl/time_setter_hex_display.sv
// BCD digit to active-low seven-segment pattern (gfedcba); non-BCD shows blank.
module hex_display
    import common_enums::*;
(
    input  logic [DIG_W-1:0] digit_i,
    output logic [SEG_W-1:0] seg_c
);

    always_comb begin
        seg_c = SEG_BLANK;
        case (digit_i)
            4'd0:    seg_c = 7'h40;
            4'd1:    seg_c = 7'h79;
            4'd2:    seg_c = 7'h24;
            4'd3:    seg_c = 7'h30;
            4'd4:    seg_c = 7'h19;
            4'd5:    seg_c = 7'h12;
            4'd6:    seg_c = 7'h02;
            4'd7:    seg_c = 7'h78;
            4'd8:    seg_c = 7'h00;
            4'd9:    seg_c = 7'h10;
            default: seg_c = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/time_setter.sv
// MM:SS preset editor: digit editing with blinking cursor, confirm/offer/ack
// handshake towards the clock consumer, and registered seven-segment outputs.
module time_setter
    import common_enums::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned BLINK_HZ    = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  screen_state_t    state,
    input  logic             btn_next,
    input  logic             btn_inc,
    input  logic             btn_dec,
    input  logic             btn_confirm,
    input  logic             preset_ack,
    output logic [CS_W-1:0]  preset_cs,
    output logic             preset_valid,
    output logic             entry_err,
    output logic [SEG_W-1:0] hex0,
    output logic [SEG_W-1:0] hex1,
    output logic [SEG_W-1:0] hex2,
    output logic [SEG_W-1:0] hex3,
    output logic [SEG_W-1:0] hex4,
    output logic [SEG_W-1:0] hex5
);

    localparam int unsigned HALF_RAW = CLK_FREQ_HZ / (2 * BLINK_HZ);
    localparam int unsigned HALF     = (HALF_RAW == 0) ? 1 : HALF_RAW;
    localparam int unsigned BLINK_W  = (HALF > 1) ? $clog2(HALF) : 1;

    time_setter_state_t state_q, state_d;
    digits_t            digits_q, digits_d;
    logic [1:0]         sel_q, sel_d;
    logic [CS_W-1:0]    preset_cs_q, preset_cs_d;
    logic               preset_valid_q, preset_valid_d;
    logic               entry_err_q, entry_err_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_on_q, blink_on_d;
    logic [SEG_W-1:0]   hex_q [4];
    logic [SEG_W-1:0]   hex_d [4];

    logic               in_setup_c;
    logic               press_c;
    logic [DIG_W-1:0]   cur_c;
    logic [DIG_W-1:0]   max_c;
    logic [DIG_W-1:0]   stepped_c;
    logic [DIG_W-1:0]   dig_c [4];
    logic [SEG_W-1:0]   seg_c [4];

    assign in_setup_c = (state == SETUP_SCREEN);
    assign press_c    = btn_next | btn_inc | btn_dec | btn_confirm;

    // Selected digit after one wrapping inc (btn_inc) or dec step.
    always_comb begin
        cur_c = digits_q.s0;
        case (sel_q)
            SEL_S1:  cur_c = digits_q.s1;
            SEL_M0:  cur_c = digits_q.m0;
            SEL_M1:  cur_c = digits_q.m1;
            default: cur_c = digits_q.s0;
        endcase
        max_c = digit_max(sel_q);
        if (btn_inc) begin
            stepped_c = (cur_c >= max_c) ? 4'd0 : cur_c + 4'd1;
        end else begin
            stepped_c = (cur_c == 4'd0) ? max_c : cur_c - 4'd1;
        end
    end

    always_comb begin
        state_d     = state_q;
        digits_d    = digits_q;
        sel_d       = sel_q;
        preset_cs_d = preset_cs_q;
        entry_err_d = 1'b0;

        case (state_q)
            TS_IDLE: begin
                if (in_setup_c) begin
                    state_d  = TS_EDIT;
                    digits_d = DEFAULT_DIGITS;
                    sel_d    = SEL_M0;
                end
            end
            TS_EDIT: begin
                if (!in_setup_c) begin
                    state_d = TS_IDLE;
                end else if (btn_confirm) begin
                    if (digits_q == '0) begin
                        entry_err_d = 1'b1;
                    end else begin
                        preset_cs_d = digits_to_cs(digits_q);
                        state_d     = TS_OFFER;
                    end
                end else if (btn_next) begin
                    sel_d = sel_q + 2'd1;
                end else if (btn_inc ^ btn_dec) begin
                    case (sel_q)
                        SEL_S1:  digits_d.s1 = stepped_c;
                        SEL_M0:  digits_d.m0 = stepped_c;
                        SEL_M1:  digits_d.m1 = stepped_c;
                        default: digits_d.s0 = stepped_c;
                    endcase
                end
            end
            TS_OFFER: begin
                if (!in_setup_c) begin
                    state_d = TS_IDLE;
                end else if (preset_ack) begin
                    state_d = TS_DONE;
                end
            end
            TS_DONE: begin
                if (!in_setup_c) begin
                    state_d = TS_IDLE;
                end
            end
            default: state_d = TS_IDLE;
        endcase

        preset_valid_d = (state_d == TS_OFFER);

        // Cursor blink restarts in the on phase on any edit-time press.
        if ((state_d != TS_EDIT) || ((state_q == TS_EDIT) && press_c)) begin
            blink_cnt_d = '0;
            blink_on_d  = 1'b1;
        end else if (blink_cnt_q == BLINK_W'(HALF - 1)) begin
            blink_cnt_d = '0;
            blink_on_d  = ~blink_on_q;
        end else begin
            blink_cnt_d = blink_cnt_q + BLINK_W'(1);
            blink_on_d  = blink_on_q;
        end
    end

    assign dig_c[0] = digits_d.s0;
    assign dig_c[1] = digits_d.s1;
    assign dig_c[2] = digits_d.m0;
    assign dig_c[3] = digits_d.m1;

    for (genvar g = 0; g < 4; g++) begin : g_hex
        hex_display u_hex_display (
            .digit_i (dig_c[g]),
            .seg_c   (seg_c[g])
        );
    end

    // Blank mux: display aligns with the state being entered this edge.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            hex_d[i] = seg_c[i];
            if (state_d == TS_IDLE) begin
                hex_d[i] = SEG_BLANK;
            end else if ((state_d == TS_EDIT) && (sel_d == 2'(i)) && !blink_on_d) begin
                hex_d[i] = SEG_BLANK;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= TS_IDLE;
            digits_q       <= DEFAULT_DIGITS;
            sel_q          <= SEL_M0;
            preset_cs_q    <= DEFAULT_PRESET_CS;
            preset_valid_q <= 1'b0;
            entry_err_q    <= 1'b0;
            blink_cnt_q    <= '0;
            blink_on_q     <= 1'b1;
            for (int i = 0; i < 4; i++) hex_q[i] <= SEG_BLANK;
        end else begin
            state_q        <= state_d;
            digits_q       <= digits_d;
            sel_q          <= sel_d;
            preset_cs_q    <= preset_cs_d;
            preset_valid_q <= preset_valid_d;
            entry_err_q    <= entry_err_d;
            blink_cnt_q    <= blink_cnt_d;
            blink_on_q     <= blink_on_d;
            for (int i = 0; i < 4; i++) hex_q[i] <= hex_d[i];
        end
    end

    assign preset_cs    = preset_cs_q;
    assign preset_valid = preset_valid_q;
    assign entry_err    = entry_err_q;
    assign hex0         = hex_q[0];
    assign hex1         = hex_q[1];
    assign hex2         = hex_q[2];
    assign hex3         = hex_q[3];
    assign hex4         = SEG_BLANK;
    assign hex5         = SEG_BLANK;

endmodule

// File: tb/tb_time_setter.sv
// Directed checks of the time_setter editor, handshake, blink and reset.
module tb_time_setter;
    import common_enums::*;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    screen_state_t scr = BOOT_SCREEN;
    logic          btn_next = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0, btn_confirm = 1'b0;
    logic          preset_ack = 1'b0;
    logic [17:0]   preset_cs;
    logic          preset_valid, entry_err;
    logic [6:0]    hex0, hex1, hex2, hex3, hex4, hex5;

    int vecs = 0;
    int errs = 0;

    localparam logic [27:0] BLANK4 = {4{7'h7F}};
    localparam logic [41:0] BLANK6 = {6{7'h7F}};

    time_setter #(.CLK_FREQ_HZ(40), .BLINK_HZ(2)) dut (
        .clk(clk), .reset_n(reset_n), .state(scr),
        .btn_next(btn_next), .btn_inc(btn_inc), .btn_dec(btn_dec), .btn_confirm(btn_confirm),
        .preset_ack(preset_ack), .preset_cs(preset_cs), .preset_valid(preset_valid),
        .entry_err(entry_err),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg7(input int d);
        case (d)
            0: seg7 = 7'h40;  1: seg7 = 7'h79;  2: seg7 = 7'h24;  3: seg7 = 7'h30;
            4: seg7 = 7'h19;  5: seg7 = 7'h12;  6: seg7 = 7'h02;  7: seg7 = 7'h78;
            8: seg7 = 7'h00;  9: seg7 = 7'h10;  default: seg7 = 7'h7F;
        endcase
    endfunction

    function automatic logic [27:0] disp(input int m1, input int m0, input int s1, input int s0);
        disp = {seg7(m1), seg7(m0), seg7(s1), seg7(s0)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic n, input logic i, input logic d, input logic c);
        btn_next = n; btn_inc = i; btn_dec = d; btn_confirm = c;
        step();
        btn_next = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0; btn_confirm = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step(); step();
        vecs++; if (preset_cs !== 18'd6000) begin $display("FAIL reset_cs got %0d want 6000", preset_cs); errs++; end
        vecs++; if (preset_valid !== 1'b0 || entry_err !== 1'b0) begin
            $display("FAIL reset_flags got valid=%b err=%b want 0 0", preset_valid, entry_err); errs++; end
        vecs++; if ({hex5, hex4, hex3, hex2, hex1, hex0} !== BLANK6) begin
            $display("FAIL reset_hex got %h want %h", {hex5, hex4, hex3, hex2, hex1, hex0}, BLANK6); errs++; end
        reset_n = 1'b1;
        step(); step();
        vecs++; if ({hex3, hex2, hex1, hex0} !== BLANK4) begin
            $display("FAIL idle_blank got %h want %h", {hex3, hex2, hex1, hex0}, BLANK4); errs++; end
    endtask

    task automatic test_basic_offer();
        scr = SETUP_SCREEN;
        step();
        vecs++; if ({hex3, hex2, hex1, hex0} !== disp(0, 1, 0, 0)) begin
            $display("FAIL edit_entry got %h want %h", {hex3, hex2, hex1, hex0}, disp(0, 1, 0, 0)); errs++; end
        press(1'b0, 1'b0, 1'b0, 1'b1);
        vecs++; if (preset_valid !== 1'b1 || preset_cs !== 18'd6000) begin
            $display("FAIL default_offer got valid=%b cs=%0d want 1 6000", preset_valid, preset_cs); errs++; end
        preset_ack = 1'b1;
        step();
        preset_ack = 1'b0;
        vecs++; if (preset_valid !== 1'b0) begin $display("FAIL ack_drop got valid=%b want 0", preset_valid); errs++; end
        press(1'b0, 1'b1, 1'b0, 1'b0);
        vecs++; if ({hex3, hex2, hex1, hex0} !== disp(0, 1, 0, 0) || preset_cs !== 18'd6000) begin
            $display("FAIL done_steady got %h cs=%0d want %h 6000", {hex3, hex2, hex1, hex0}, preset_cs, disp(0, 1, 0, 0)); errs++; end
        scr = BOOT_SCREEN;
        step();
        vecs++; if ({hex3, hex2, hex1, hex0} !== BLANK4 || preset_cs !== 18'd6000) begin
            $display("FAIL done_to_idle got %h cs=%0d want blank 6000", {hex3, hex2, hex1, hex0}, preset_cs); errs++; end
    endtask

    task automatic test_zero_error();
        scr = SETUP_SCREEN;
        step();
        press(1'b0, 1'b0, 1'b1, 1'b0);
        vecs++; if ({hex3, hex2, hex1, hex0} !== disp(0, 0, 0, 0)) begin
            $display("FAIL dec_to_zero got %h want %h", {hex3, hex2, hex1, hex0}, disp(0, 0, 0, 0)); errs++; end
        press(1'b0, 1'b0, 1'b0, 1'b1);
        vecs++; if (entry_err !== 1'b1 || preset_valid !== 1'b0 || preset_cs !== 18'd6000) begin
            $display("FAIL zero_reject got err=%b valid=%b cs=%0d want 1 0 6000", entry_err, preset_valid, preset_cs); errs++; end
        step();
        vecs++; if (entry_err !== 1'b0 || {hex3, hex2, hex1, hex0} !== disp(0, 0, 0, 0)) begin
            $display("FAIL err_pulse_len got err=%b hex=%h want 0 %h", entry_err, {hex3, hex2, hex1, hex0}, disp(0, 0, 0, 0)); errs++; end
    endtask

    task automatic test_saturate();
        press(1'b0, 1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        vecs++; if ({hex3, hex2, hex1, hex0} !== disp(3, 9, 5, 9)) begin
            $display("FAIL dec_wraps got %h want %h", {hex3, hex2, hex1, hex0}, disp(3, 9, 5, 9)); errs++; end
        press(1'b0, 1'b0, 1'b0, 1'b1);
        vecs++; if (preset_valid !== 1'b1 || preset_cs !== 18'd180000) begin
            $display("FAIL saturate got valid=%b cs=%0d want 1 180000", preset_valid, preset_cs); errs++; end
        scr = CHESS_SCREEN;
        step();
        vecs++; if (preset_valid !== 1'b0 || {hex3, hex2, hex1, hex0} !== BLANK4 || preset_cs !== 18'd180000) begin
            $display("FAIL offer_leave got valid=%b hex=%h cs=%0d want 0 blank 180000", preset_valid, {hex3, hex2, hex1, hex0}, preset_cs); errs++; end
    endtask

    task automatic test_offer_freeze();
        scr = SETUP_SCREEN;
        step();
        press(1'b0, 1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (5) press(1'b0, 1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) press(1'b0, 1'b1, 1'b0, 1'b0);
        vecs++; if ({hex3, hex2, hex1, hex0} !== disp(0, 2, 3, 5)) begin
            $display("FAIL set_0235 got %h want %h", {hex3, hex2, hex1, hex0}, disp(0, 2, 3, 5)); errs++; end
        press(1'b0, 1'b0, 1'b0, 1'b1);
        vecs++; if (preset_valid !== 1'b1 || preset_cs !== 18'd15500) begin
            $display("FAIL offer_0235 got valid=%b cs=%0d want 1 15500", preset_valid, preset_cs); errs++; end
        press(1'b0, 1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b1, 1'b0);
        vecs++; if (preset_valid !== 1'b1 || preset_cs !== 18'd15500 || {hex3, hex2, hex1, hex0} !== disp(0, 2, 3, 5)) begin
            $display("FAIL offer_frozen got valid=%b cs=%0d hex=%h want 1 15500 %h", preset_valid, preset_cs, {hex3, hex2, hex1, hex0}, disp(0, 2, 3, 5)); errs++; end
        scr = CHESS_SCREEN;
        step();
        vecs++; if (preset_valid !== 1'b0 || {hex3, hex2, hex1, hex0} !== BLANK4 || preset_cs !== 18'd15500) begin
            $display("FAIL chess_exit got valid=%b hex=%h cs=%0d want 0 blank 15500", preset_valid, {hex3, hex2, hex1, hex0}, preset_cs); errs++; end
    endtask

    task automatic test_wrap_and_simul();
        scr = SETUP_SCREEN;
        step();
        repeat (3) press(1'b1, 1'b0, 1'b0, 1'b0);
        preset_ack = 1'b1;
        press(1'b0, 1'b0, 1'b1, 1'b0);
        preset_ack = 1'b0;
        vecs++; if ({hex3, hex2, hex1, hex0} !== disp(0, 1, 5, 0) || preset_valid !== 1'b0) begin
            $display("FAIL s1_dec_wrap got %h valid=%b want %h 0", {hex3, hex2, hex1, hex0}, preset_valid, disp(0, 1, 5, 0)); errs++; end
        press(1'b0, 1'b1, 1'b0, 1'b0);
        vecs++; if ({hex3, hex2, hex1, hex0} !== disp(0, 1, 0, 0)) begin
            $display("FAIL s1_inc_wrap got %h want %h", {hex3, hex2, hex1, hex0}, disp(0, 1, 0, 0)); errs++; end
        press(1'b0, 1'b1, 1'b1, 1'b0);
        vecs++; if ({hex3, hex2, hex1, hex0} !== disp(0, 1, 0, 0)) begin
            $display("FAIL inc_dec_cancel got %h want %h", {hex3, hex2, hex1, hex0}, disp(0, 1, 0, 0)); errs++; end
        repeat (4) press(1'b1, 1'b0, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0, 1'b0);
        vecs++; if ({hex3, hex2, hex1, hex0} !== disp(0, 1, 1, 0)) begin
            $display("FAIL sel_wrap4 got %h want %h", {hex3, hex2, hex1, hex0}, disp(0, 1, 1, 0)); errs++; end
    endtask

    task automatic test_blink();
        repeat (9) step();
        vecs++; if ({hex3, hex2, hex1, hex0} !== disp(0, 1, 1, 0)) begin
            $display("FAIL blink_on got %h want %h", {hex3, hex2, hex1, hex0}, disp(0, 1, 1, 0)); errs++; end
        step();
        vecs++; if ({hex3, hex2, hex1, hex0} !== {seg7(0), seg7(1), 7'h7F, seg7(0)}) begin
            $display("FAIL blink_off got %h want %h", {hex3, hex2, hex1, hex0}, {seg7(0), seg7(1), 7'h7F, seg7(0)}); errs++; end
        press(1'b1, 1'b0, 1'b0, 1'b0);
        vecs++; if ({hex3, hex2, hex1, hex0} !== disp(0, 1, 1, 0)) begin
            $display("FAIL blink_restart got %h want %h", {hex3, hex2, hex1, hex0}, disp(0, 1, 1, 0)); errs++; end
    endtask

    task automatic test_priority();
        press(1'b1, 1'b1, 1'b0, 1'b0);
        vecs++; if ({hex3, hex2, hex1, hex0} !== disp(0, 1, 1, 0)) begin
            $display("FAIL next_over_inc got %h want %h", {hex3, hex2, hex1, hex0}, disp(0, 1, 1, 0)); errs++; end
        press(1'b1, 1'b1, 1'b0, 1'b1);
        vecs++; if (preset_valid !== 1'b1 || preset_cs !== 18'd7000 || {hex3, hex2, hex1, hex0} !== disp(0, 1, 1, 0)) begin
            $display("FAIL confirm_first got valid=%b cs=%0d hex=%h want 1 7000 %h", preset_valid, preset_cs, {hex3, hex2, hex1, hex0}, disp(0, 1, 1, 0)); errs++; end
    endtask

    task automatic test_reset_mid_offer();
        #2;
        reset_n = 1'b0;
        #1;
        vecs++; if (preset_valid !== 1'b0 || preset_cs !== 18'd6000 || entry_err !== 1'b0) begin
            $display("FAIL async_reset got valid=%b cs=%0d err=%b want 0 6000 0", preset_valid, preset_cs, entry_err); errs++; end
        vecs++; if ({hex5, hex4, hex3, hex2, hex1, hex0} !== BLANK6) begin
            $display("FAIL async_reset_hex got %h want %h", {hex5, hex4, hex3, hex2, hex1, hex0}, BLANK6); errs++; end
        scr = BOOT_SCREEN;
        step();
        reset_n = 1'b1;
        step();
        vecs++; if ({hex3, hex2, hex1, hex0} !== BLANK4 || preset_valid !== 1'b0) begin
            $display("FAIL post_reset got hex=%h valid=%b want blank 0", {hex3, hex2, hex1, hex0}, preset_valid); errs++; end
    endtask

    initial begin
        test_reset();
        test_basic_offer();
        test_zero_error();
        test_saturate();
        test_offer_freeze();
        test_wrap_and_simul();
        test_blink();
        test_priority();
        test_reset_mid_offer();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/time_setter.md
TIME_SETTER -- requirements
Module: time_setter

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BLINK_HZ, default 2, blink rate of the selected digit.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port state  input  screen_state_t  FSM screen state from the shared package.
REQ-006 SHALL have ports btn_next, btn_inc, btn_dec, btn_confirm  input  1 each  single-cycle, already-debounced press pulses.
REQ-007 SHALL have port preset_ack  input  1  consumer accepts the offered preset.
REQ-008 SHALL have port preset_cs  output  18  preset time in centiseconds.
REQ-009 SHALL have port preset_valid  output  1  preset_cs is offered and stable.
REQ-010 SHALL have port entry_err  output  1  one-cycle pulse on a rejected confirm.
REQ-011 SHALL have ports hex0..hex5  output  7 each  active-low segments (hex3..hex0 = M1 M0 S1 S0).

Function
REQ-012 SHALL hold four BCD digits: M1 (range 0-3), M0 (0-9), S1 (0-5), S0 (0-9), plus a 2-bit select index sel (0=S0, 1=S1, 2=M0, 3=M1).
REQ-013 SHALL implement states IDLE, EDIT, OFFER, DONE.
REQ-014 IDLE: when state==SETUP_SCREEN, SHALL go to EDIT next cycle, load digits 01:00, and set sel=2.
REQ-015 EDIT: btn_next SHALL advance sel by 1, wrapping from 3 to 0.
REQ-016 EDIT: btn_inc SHALL add 1 to the selected digit, wrapping from its maximum to 0; btn_dec SHALL subtract 1, wrapping from 0 to its maximum.
REQ-017 EDIT: when btn_inc and btn_dec are both high, the digit SHALL be unchanged.
REQ-018 EDIT: button priority SHALL be confirm > next > inc/dec; only the highest-priority pressed button acts in a cycle.
REQ-019 EDIT confirm: preset_cs SHALL be registered as (10*M1+M0)*6000 + (10*S1+S0)*100, saturated to 180000; the FSM SHALL then enter OFFER.
REQ-020 EDIT confirm with digits 00:00: the FSM SHALL stay in EDIT, pulse entry_err for one cycle, and leave preset_cs unchanged.
REQ-021 OFFER: preset_valid SHALL be 1; preset_cs and the digits SHALL be frozen; buttons SHALL be ignored.
REQ-022 OFFER with preset_ack high: the FSM SHALL go to DONE next cycle and preset_valid SHALL fall.
REQ-023 preset_ack outside OFFER SHALL be ignored.
REQ-024 DONE: preset_cs SHALL be held; the FSM SHALL return to IDLE when state!=SETUP_SCREEN.
REQ-025 In EDIT or OFFER, when state!=SETUP_SCREEN, the FSM SHALL go to IDLE next cycle and preset_valid SHALL drop; preset_cs SHALL keep its last value.
REQ-026 Blink counter SHALL toggle phase every CLK_FREQ_HZ/(2*BLINK_HZ) cycles; in EDIT the selected digit SHALL be blank (7'h7F) in the off phase.
REQ-027 Any button press in EDIT SHALL clear the blink counter and force the on phase.
REQ-028 hex5 and hex4 SHALL always be blank (7'h7F).
REQ-029 In IDLE the four digit displays SHALL be blank; in OFFER and DONE they SHALL show steady digits.
REQ-030 Digit-to-binary arithmetic SHALL use at least 18-bit widths with no intermediate truncation.

Reset
REQ-031 On reset_n low, the block SHALL asynchronously enter IDLE with digits 01:00, sel=2, preset_cs=6000, preset_valid=0, entry_err=0, blink counter=0, hex0..hex5=7'h7F.
REQ-032 Reset asserted mid-OFFER SHALL drop preset_valid immediately, without waiting for a clock edge.

Structure
REQ-033 The shared package common_enums SHALL hold time_setter_state_t, MAX_PRESET_CS=180000, DEFAULT_PRESET_CS=6000, and the per-digit maximum constants.
REQ-034 The block SHALL instantiate the existing hex_display sub-module for each digit, followed by a blank mux; no other sub-modules.

Verification
REQ-035 Reset, then state=SETUP_SCREEN, then btn_confirm -> preset_valid=1 with preset_cs=6000; preset_ack -> preset_valid=0 next cycle, DONE.
REQ-036 From 01:00 with sel=2: btn_dec, then btn_confirm -> entry_err pulses for 1 cycle, FSM stays in EDIT, preset_valid=0.
REQ-037 Set M1=3, M0=9, S1=5, S0=9, then confirm -> preset_cs=180000 (saturated).
REQ-038 Set 02:35, then confirm -> preset_cs=15500; btn_inc during OFFER -> digits and preset_cs unchanged.
REQ-039 sel=1 (S1=5), btn_inc -> S1=0; btn_inc and btn_dec in the same cycle -> no change; btn_next four times -> sel returns to its start value.
REQ-040 With preset_valid=1, state->CHESS_SCREEN -> preset_valid=0 next cycle and hex3..hex0=7'h7F; reset_n pulsed low mid-OFFER -> outputs take REQ-031 values asynchronously.
